// File: rtl/ws2812b_bit_engine.sv
// ws2812b_bit_engine: serialises 24-bit pixel words into the WS2812B
// single-wire NRZ waveform, MSB first. A one-word holding register lets the
// next word follow with no gap. A per-word latch flag appends the strip reset
// low period.
// Optional feature: define WS2812B_DIM_EN to right-shift each 8-bit channel by
// DIM_SHIFT at load time. Without the macro, words are sent unmodified.
module ws2812b_bit_engine #(
  parameter int T0H       = 8,
  parameter int T1H       = 16,
  parameter int TBIT      = 25,
  parameter int TRESET    = 6000,
  parameter int DIM_SHIFT = 1
) (
  input  logic        clk20,
  input  logic        reset,
  input  logic [23:0] data_in,
  input  logic        valid,
  input  logic        latch,
  output logic        ready,
  output logic        led,
  output logic        busy,
  output logic        underrun
);

  localparam logic [15:0] T0H_C       = 16'(T0H);
  localparam logic [15:0] T1H_C       = 16'(T1H);
  localparam logic [15:0] TBIT_LAST   = 16'(TBIT - 1);
  localparam logic [15:0] TRESET_LAST = 16'(TRESET - 1);

  typedef enum logic [1:0] {S_IDLE, S_BIT, S_LATCH} state_t;

  // Reject timing or dim settings the counters and waveform cannot honour.
  if (!(T0H > 0 && T0H < T1H && T1H < TBIT && TBIT <= 65536 &&
        TRESET >= 1 && TRESET <= 65535 && DIM_SHIFT >= 0 && DIM_SHIFT <= 7))
  begin : g_bad_params
    $error("ws2812b_bit_engine: illegal timing or dim parameters");
  end

`ifdef WS2812B_DIM_EN
  function automatic logic [23:0] prep_word(input logic [23:0] w);
    return {w[23:16] >> DIM_SHIFT, w[15:8] >> DIM_SHIFT, w[7:0] >> DIM_SHIFT};
  endfunction
`else
  function automatic logic [23:0] prep_word(input logic [23:0] w);
    return w;
  endfunction
`endif

  state_t      state,      state_nxt;
  logic [23:0] shift_q,    shift_nxt;
  logic [4:0]  bit_cnt,    bit_nxt;
  logic [15:0] cyc_cnt,    cyc_nxt;
  logic        word_latch, word_latch_nxt;
  logic [23:0] hold_data,  hold_data_nxt;
  logic        hold_latch, hold_latch_nxt;
  logic        hold_full,  hold_full_nxt;
  logic        ready_nxt, led_nxt, busy_nxt, underrun_nxt;
  logic        accept, load;

  // Next-state, holding-register and registered-output logic.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves a latch behind.
    state_nxt      = state;
    shift_nxt      = shift_q;
    bit_nxt        = bit_cnt;
    cyc_nxt        = cyc_cnt;
    word_latch_nxt = word_latch;
    hold_data_nxt  = hold_data;
    hold_latch_nxt = hold_latch;
    hold_full_nxt  = hold_full;
    underrun_nxt   = 1'b0;
    load           = 1'b0;

    // ready mirrors ~hold_full, so an accept never collides with a load.
    accept = valid && ready;
    if (accept) begin
      hold_data_nxt  = data_in;
      hold_latch_nxt = latch;
      hold_full_nxt  = 1'b1;
    end

    case (state)
      S_IDLE: begin
        if (hold_full) load = 1'b1;
      end
      S_BIT: begin
        if (cyc_cnt == TBIT_LAST) begin
          if (bit_cnt != 5'd0) begin
            shift_nxt = {shift_q[22:0], 1'b0};
            bit_nxt   = bit_cnt - 5'd1;
            cyc_nxt   = '0;
          end else if (word_latch) begin
            state_nxt = S_LATCH;
            cyc_nxt   = '0;
          end else if (hold_full) begin
            load = 1'b1;
          end else begin
            underrun_nxt = 1'b1;
            state_nxt    = S_IDLE;
            cyc_nxt      = '0;
          end
        end else begin
          cyc_nxt = cyc_cnt + 16'd1;
        end
      end
      S_LATCH: begin
        if (cyc_cnt == TRESET_LAST) begin
          // A word held during the latch starts on the very next cycle.
          cyc_nxt = '0;
          if (hold_full) load = 1'b1;
          else           state_nxt = S_IDLE;
        end else begin
          cyc_nxt = cyc_cnt + 16'd1;
        end
      end
      default: begin
        state_nxt = S_IDLE;
        cyc_nxt   = '0;
      end
    endcase

    if (load) begin
      state_nxt      = S_BIT;
      shift_nxt      = prep_word(hold_data);
      bit_nxt        = 5'd23;
      cyc_nxt        = '0;
      word_latch_nxt = hold_latch;
      hold_full_nxt  = 1'b0;
    end

    ready_nxt = !hold_full_nxt;
    busy_nxt  = (state_nxt != S_IDLE) || hold_full_nxt;
    led_nxt   = (state_nxt == S_BIT) &&
                (cyc_nxt < (shift_nxt[23] ? T1H_C : T0H_C));
  end

  // State, datapath and output registers with asynchronous reset.
  always_ff @(posedge clk20 or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      shift_q    <= '0;
      bit_cnt    <= '0;
      cyc_cnt    <= '0;
      word_latch <= 1'b0;
      // NOTE: the holding register is reset too; a held word must not survive
      // a reset and restart after it.
      hold_data  <= '0;
      hold_latch <= 1'b0;
      hold_full  <= 1'b0;
      ready      <= 1'b1;
      led        <= 1'b0;
      busy       <= 1'b0;
      underrun   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state      <= state_nxt;
      shift_q    <= shift_nxt;
      bit_cnt    <= bit_nxt;
      cyc_cnt    <= cyc_nxt;
      word_latch <= word_latch_nxt;
      hold_data  <= hold_data_nxt;
      hold_latch <= hold_latch_nxt;
      hold_full  <= hold_full_nxt;
      ready      <= ready_nxt;
      led        <= led_nxt;
      busy       <= busy_nxt;
      underrun   <= underrun_nxt;
    end
  end

endmodule

// File: tb/tb_ws2812b_bit_engine.sv
// Testbench for ws2812b_bit_engine: stimulus pushes expected words into a
// scoreboard queue; a monitor decodes the led waveform into words and checks
// them, the latch period, gaps and underrun pulses against the queue.
module tb_ws2812b_bit_engine;

  localparam int T0H    = 8;
  localparam int T1H    = 16;
  localparam int TBIT   = 25;
  localparam int TRESET = 6000;
  localparam int DIM    = 2;

  logic        clk20 = 1'b0;
  logic        reset;
  logic [23:0] data_in;
  logic        valid, latch;
  logic        ready, led, busy, underrun;

  ws2812b_bit_engine #(
    .T0H(T0H), .T1H(T1H), .TBIT(TBIT), .TRESET(TRESET), .DIM_SHIFT(DIM)
  ) dut (
    .clk20(clk20), .reset(reset), .data_in(data_in), .valid(valid),
    .latch(latch), .ready(ready), .led(led), .busy(busy), .underrun(underrun)
  );

  always #25 clk20 = ~clk20;

  typedef struct {
    logic [23:0] data;
    logic        latch;
    int          acc;    // cycle number of the accepting edge
  } word_t;

  word_t       exp_q[$];
  int          n_tests = 0, n_fail = 0;
  int          cycle = 0, n_underrun = 0, exp_underrun = 0;
  bit          mon_enable = 1'b0, mon_busy = 1'b0;
  logic [23:0] last_word = '0;

  always @(posedge clk20) cycle <= cycle + 1;
  always @(negedge clk20) if (underrun === 1'b1) n_underrun <= n_underrun + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  task automatic fail_now(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s (cycle %0d)", name, cycle);
  endtask

  // Reference: each 8-bit channel divided by 2**DIM when dimming is built in.
  function automatic logic [23:0] model(input logic [23:0] d);
    logic [23:0] r;
    r = d;
`ifdef WS2812B_DIM_EN
    for (int c = 0; c < 3; c++) r[c*8 +: 8] = 8'(int'(d[c*8 +: 8]) / (1 << DIM));
`endif
    return r;
  endfunction

  // Decode one word starting at its first high sample, then check what follows.
  task automatic decode_word();
    word_t       e;
    logic [23:0] got;
    bit          shape_ok, lat_ok, expect_next, have;
    int          h, l;
    mon_busy = 1'b1;
    got      = '0;
    shape_ok = 1'b1;
    lat_ok   = 1'b1;
    for (int b = 23; b >= 0; b--) begin
      h = 0;
      while (led === 1'b1 && h < TBIT) begin h++; @(negedge clk20); end
      l = 0;
      while (led === 1'b0 && h + l < TBIT) begin l++; @(negedge clk20); end
      got[b] = (h == T1H);
      if (!((h == T0H || h == T1H) && h + l == TBIT)) shape_ok = 1'b0;
    end
    last_word = got;
    check("bit_shape", 32'(shape_ok), 32'd1);
    have = exp_q.size() > 0;
    if (have) begin
      e = exp_q.pop_front();
      check("word_data", 32'(got), 32'(e.data));
    end else begin
      fail_now("unexpected_word");
      e.latch = 1'b0;
    end
    if (e.latch) begin
      l = 0;
      while (led === 1'b0 && l < TRESET) begin
        if (underrun === 1'b1 || busy !== 1'b1) lat_ok = 1'b0;
        l++;
        @(negedge clk20);
      end
      check("latch_len", 32'(l), 32'(TRESET));
      check("latch_quiet", 32'(lat_ok), 32'd1);
    end
    // A word accepted before the ending edge must start with no gap.
    expect_next = exp_q.size() > 0 && exp_q[0].acc < cycle;
    check("next_start", 32'(led), 32'(expect_next));
    if (!e.latch && !expect_next) begin
      check("underrun_pulse", 32'(underrun), 32'd1);
      exp_underrun++;
    end
    mon_busy = 1'b0;
  endtask

  // Monitor: decode whenever a word starts on the line.
  initial begin : monitor
    forever begin
      if (mon_enable && led === 1'b1) decode_word();
      else @(negedge clk20);
    end
  end

  // Offer a word; scramble data/latch while ready is low, then present it.
  task automatic send_word(input logic [23:0] d, input logic l, input bit push);
    word_t e;
    int    guard;
    guard = 0;
    @(negedge clk20);
    valid = 1'b1;
    while (ready !== 1'b1 && guard < 20000) begin
      data_in = 24'($urandom);
      latch   = 1'($urandom);
      @(negedge clk20);
      guard++;
    end
    if (guard >= 20000) begin
      fail_now("ready_timeout");
    end else begin
      data_in = d;
      latch   = l;
      if (push) begin
        e.data  = model(d);
        e.latch = l;
        e.acc   = cycle + 1;
        exp_q.push_back(e);
      end
    end
    @(negedge clk20);
    valid   = 1'b0;
    data_in = 24'($urandom);
    latch   = 1'b0;
  endtask

  task automatic wait_idle();
    int g;
    g = 0;
    do begin
      @(negedge clk20);
      #1;
      g++;
    end while (!(busy === 1'b0 && !mon_busy && exp_q.size() == 0) && g < 20000);
    if (g >= 20000) fail_now("idle_timeout");
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk20);
  endtask

  initial begin : watchdog
    wait_cycles(95000);
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    int u0, g, bad;
    logic [23:0] d;
    reset = 1'b0; valid = 1'b0; data_in = '0; latch = 1'b0;
    #1 reset = 1'b1;
    #9;
    check("rst_led", 32'(led), 32'd0);
    check("rst_ready", 32'(ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_underrun", 32'(underrun), 32'd0);
    wait_cycles(2);
    reset = 1'b0;
    mon_enable = 1'b1;

    // Single word, with accept and first-bit latency.
    u0 = n_underrun;
    send_word(24'hAA0000, 1'b0, 1'b1);
    check("acc_ready", 32'(ready), 32'd0);
    check("acc_busy", 32'(busy), 32'd1);
    check("acc_led", 32'(led), 32'd0);
    @(negedge clk20);
    check("load_led", 32'(led), 32'd1);
    check("load_ready", 32'(ready), 32'd1);
    wait_idle();
    check("single_word", 32'(last_word), 32'(model(24'hAA0000)));
    check("single_underruns", 32'(n_underrun - u0), 32'd1);
    check("single_led_low", 32'(led), 32'd0);

    // Back-to-back words.
    u0 = n_underrun;
    send_word(24'hFFFFFF, 1'b0, 1'b1);
    send_word(24'h000000, 1'b0, 1'b1);
    g = 0;
    while (ready !== 1'b1 && g < 2 * 24 * TBIT) begin @(negedge clk20); g++; end
    check("b2b_ready_back", 32'(ready), 32'd1);
    wait_idle();
    check("b2b_underruns", 32'(n_underrun - u0), 32'd1);

    // Latched word with nothing following.
    u0 = n_underrun;
    send_word(24'h00FF00, 1'b1, 1'b1);
    wait_idle();
    check("latch_underruns", 32'(n_underrun - u0), 32'd0);

    // Latched word, next word accepted during LATCH.
    u0 = n_underrun;
    send_word(24'h00FF00, 1'b1, 1'b1);
    wait_cycles(24 * TBIT + 50);
    send_word(24'h0F0F0F, 1'b0, 1'b1);
    wait_idle();
    check("latch_next_word", 32'(last_word), 32'(model(24'h0F0F0F)));
    check("latch_next_underruns", 32'(n_underrun - u0), 32'd1);

    // Dimming.
    send_word(24'hFF8040, 1'b0, 1'b1);
    wait_idle();
`ifdef WS2812B_DIM_EN
    check("dim_word", 32'(last_word), 32'h3F2010);
`else
    check("dim_word", 32'(last_word), 32'hFF8040);
`endif

    // Asynchronous reset mid-bit.
    mon_enable = 1'b0;
    send_word(24'h800000, 1'b0, 1'b0);
    wait_cycles(4);
    check("pre_rst_led_high", 32'(led), 32'd1);
    #5 reset = 1'b1;
    #1;
    check("rst_bit_led", 32'(led), 32'd0);
    check("rst_bit_ready", 32'(ready), 32'd1);
    check("rst_bit_busy", 32'(busy), 32'd0);
    @(negedge clk20);
    reset = 1'b0;

    // Asynchronous reset mid-LATCH with a word held.
    send_word(24'h000001, 1'b1, 1'b0);
    wait_cycles(24 * TBIT + 100);
    send_word(24'hABCDEF, 1'b0, 1'b0);
    check("pre_rst_latch_busy", 32'(busy), 32'd1);
    check("pre_rst_latch_ready", 32'(ready), 32'd0);
    #5 reset = 1'b1;
    #1;
    check("rst_latch_led", 32'(led), 32'd0);
    check("rst_latch_ready", 32'(ready), 32'd1);
    check("rst_latch_busy", 32'(busy), 32'd0);
    @(negedge clk20);
    reset = 1'b0;
    bad = 0;
    repeat (700) begin
      @(negedge clk20);
      if (led !== 1'b0 || busy !== 1'b0) bad++;
    end
    check("held_word_dropped", 32'(bad), 32'd0);
    mon_enable = 1'b1;
    send_word(24'h123456, 1'b0, 1'b1);
    wait_idle();
    check("post_rst_word", 32'(last_word), 32'(model(24'h123456)));

    // Randomised traffic with mixed gaps and occasional latches.
    for (int i = 0; i < 12; i++) begin
      d = 24'($urandom);
      send_word(d, ($urandom_range(0, 5) == 0), 1'b1);
      case ($urandom_range(0, 3))
        0: ;
        1: wait_cycles($urandom_range(1, 30));
        2: wait_cycles($urandom_range(24 * TBIT - 5, 24 * TBIT + 40));
        default: wait_idle();
      endcase
    end
    wait_idle();
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    check("underrun_total", 32'(n_underrun), 32'(exp_underrun));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
